// File: rtl/am_pkg.sv
// Shared constants and offset-binary helpers for the AM modulator/demodulator chain.
package am_pkg;

    localparam int DW = 12;
    localparam logic [DW-1:0] MIDSCALE = 12'h800;

    function automatic logic signed [DW-1:0] ob2s(input logic [DW-1:0] ob);
        return $signed({~ob[DW-1], ob[DW-2:0]});
    endfunction

    function automatic logic [DW-1:0] s2ob(input logic signed [DW-1:0] s);
        return {~s[DW-1], s[DW-2:0]};
    endfunction

    // Overflow shows up as the two top bits disagreeing.
    function automatic logic signed [DW-1:0] saturate(input logic signed [DW:0] v);
        logic signed [DW-1:0] r;
        if (v[DW] != v[DW-1]) begin
            r = v[DW] ? $signed({1'b1, {(DW-1){1'b0}}}) : $signed({1'b0, {(DW-1){1'b1}}});
        end else begin
            r = v[DW-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/am_demod_if.sv
// Sample-in / envelope-and-message-out bundle of the AM demodulator.
interface am_demod_if;

    logic                    in_valid;
    logic [am_pkg::DW-1:0]   adc_data;
    logic [am_pkg::DW-1:0]   env_data;
    logic                    env_valid;
    logic [am_pkg::DW-1:0]   demod_data;
    logic                    demod_valid;

    modport master (
        output in_valid, adc_data,
        input  env_data, env_valid, demod_data, demod_valid
    );

    modport slave (
        input  in_valid, adc_data,
        output env_data, env_valid, demod_data, demod_valid
    );

endinterface

// File: rtl/am_demod_dc_track.sv
// Leaky DC tracker: removes the carrier level from the envelope, primed by the first dump.
module am_demod_dc_track
    import am_pkg::*;
#(
    parameter int DC_SHIFT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          env_valid_i,
    input  logic [DW-1:0] env_data_i,
    output logic          demod_valid_o,
    output logic [DW-1:0] demod_data_o
);

    localparam int ACC_W = DW + DC_SHIFT + 1;

    logic [ACC_W-1:0]      dc_acc_q, dc_acc_d;
    logic                  primed_q, primed_d;
    logic [DW-1:0]         demod_q, demod_d;
    logic                  demod_valid_q;
    logic [DW:0]           dc_s;
    logic signed [DW:0]    ac_s;
    logic signed [DW-1:0]  sat_s;

    // env and dc are both within 0..2048, so the difference fits DW+1 bits.
    assign dc_s  = dc_acc_q[DC_SHIFT +: DW+1];
    assign ac_s  = $signed({1'b0, env_data_i}) - $signed(dc_s);
    assign sat_s = saturate(ac_s);

    // Next-state for the tracker; the accumulator integrates the unsaturated error.
    always_comb begin
        dc_acc_d = dc_acc_q;
        primed_d = primed_q;
        demod_d  = demod_q;
        if (env_valid_i) begin
            if (primed_q) begin
                dc_acc_d = dc_acc_q + {{(ACC_W-DW-1){ac_s[DW]}}, ac_s};
                demod_d  = s2ob(sat_s);
            end else begin
                dc_acc_d = {1'b0, env_data_i, {DC_SHIFT{1'b0}}};
                primed_d = 1'b1;
                demod_d  = MIDSCALE;
            end
        end else begin
            dc_acc_d = dc_acc_q;
            primed_d = primed_q;
            demod_d  = demod_q;
        end
    end

    // Tracker state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            dc_acc_q      <= {ACC_W{1'b0}};
            primed_q      <= 1'b0;
            demod_q       <= MIDSCALE;
            demod_valid_q <= 1'b0;
        end else begin
            dc_acc_q      <= dc_acc_d;
            primed_q      <= primed_d;
            demod_q       <= demod_d;
            demod_valid_q <= env_valid_i;
        end
    end

    assign demod_valid_o = demod_valid_q;
    assign demod_data_o  = demod_q;

endmodule

// File: rtl/am_demod.sv
// AM envelope demodulator: rectify, integrate-and-dump, then strip the carrier DC.
module am_demod
    import am_pkg::*;
#(
    parameter int DEC_LOG2 = 6,
    parameter int DC_SHIFT = 8
) (
    input  logic        clk,
    input  logic        rst,
    am_demod_if.slave   bus
);

    localparam int ACC_W = DW + DEC_LOG2;

    logic                  s1_valid_q;
    logic signed [DW-1:0]  s1_data_q;
    logic                  s2_valid_q;
    logic [DW-1:0]         s2_mag_q;
    logic [DW-1:0]         mag_s;
    logic [ACC_W-1:0]      acc_q, acc_d, sum_s;
    logic [DEC_LOG2-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]         env_q, env_d;
    logic                  env_valid_q, env_valid_d;
    logic                  demod_valid_s;
    logic [DW-1:0]         demod_data_s;

    // Two's-complement negate in DW bits leaves -2048 as 0x800, i.e. 2048 unsigned.
    assign mag_s = s1_data_q[DW-1] ? (~$unsigned(s1_data_q) + {{(DW-1){1'b0}}, 1'b1})
                                   : $unsigned(s1_data_q);
    assign sum_s = acc_q + {{DEC_LOG2{1'b0}}, s2_mag_q};

    // Window accumulation; the last sample is folded into the dump, not the next window.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        env_d       = env_q;
        env_valid_d = 1'b0;
        if (s2_valid_q) begin
            if (cnt_q == {DEC_LOG2{1'b1}}) begin
                env_d       = sum_s[DEC_LOG2 +: DW];
                env_valid_d = 1'b1;
                acc_d       = {ACC_W{1'b0}};
                cnt_d       = {DEC_LOG2{1'b0}};
            end else begin
                acc_d = sum_s;
                cnt_d = cnt_q + {{(DEC_LOG2-1){1'b0}}, 1'b1};
            end
        end else begin
            acc_d = acc_q;
            cnt_d = cnt_q;
        end
    end

    // Input capture, rectifier and integrate-and-dump registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= {DW{1'b0}};
            s2_valid_q  <= 1'b0;
            s2_mag_q    <= {DW{1'b0}};
            acc_q       <= {ACC_W{1'b0}};
            cnt_q       <= {DEC_LOG2{1'b0}};
            env_q       <= {DW{1'b0}};
            env_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= bus.in_valid;
            s1_data_q   <= bus.in_valid ? ob2s(bus.adc_data) : s1_data_q;
            s2_valid_q  <= s1_valid_q;
            s2_mag_q    <= mag_s;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            env_q       <= env_d;
            env_valid_q <= env_valid_d;
        end
    end

    am_demod_dc_track #(
        .DC_SHIFT(DC_SHIFT)
    ) u_dc_track (
        .clk          (clk),
        .rst          (rst),
        .env_valid_i  (env_valid_q),
        .env_data_i   (env_q),
        .demod_valid_o(demod_valid_s),
        .demod_data_o (demod_data_s)
    );

    assign bus.env_data    = env_q;
    assign bus.env_valid   = env_valid_q;
    assign bus.demod_data  = demod_data_s;
    assign bus.demod_valid = demod_valid_s;

endmodule
